// File: rtl/hub_rx_if.sv
// Signal bundle between the hub_rx receiver (slave) and the sender/host side (master).
// Serial link: trd/sd/cd/sbf. Host side: req, FIFO pop/peek and transfer status.
interface hub_rx_if #(
  parameter int DEPTH = 32
);
  logic                   trd;
  logic                   sd;
  logic                   cd;
  logic                   req;
  logic                   sbf;
  logic                   rd_en;
  logic [7:0]             rd_data;
  logic                   empty;
  logic [$clog2(DEPTH):0] byte_count;
  logic                   busy;
  logic                   done;
  logic                   err_overflow;
  logic                   err_frame;
  logic                   err_timeout;

  modport master (
    output trd, sd, cd, req, rd_en,
    input  sbf, rd_data, empty, byte_count, busy, done,
           err_overflow, err_frame, err_timeout
  );

  modport slave (
    input  trd, sd, cd, req, rd_en,
    output sbf, rd_data, empty, byte_count, busy, done,
           err_overflow, err_frame, err_timeout
  );
endinterface

// File: rtl/hub_rx.sv
// Serial dump receiver: deframes start-bit + 8 LSB-first bits into a FWFT byte FIFO.
// Optional macro HUB_RX_AUTO_REQ_EN: trigger on trd rising edge instead of the req pulse.
module hub_rx #(
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic    clk,
  input  logic    reset,
  hub_rx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_START, DATA, GAP} state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    mem [DEPTH];
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic [TW-1:0] timer;
  logic          sbf_q;
  logic          busy_q;
  logic          done_q;
  logic          ovf_q;
  logic          frm_q;
  logic          to_q;
  logic          trigger;
  logic          full;
  logic          empty_w;
  logic          do_wr;
  logic          do_pop;
  logic [7:0]    wr_byte;

`ifdef HUB_RX_AUTO_REQ_EN
  logic trd_q;
  logic unused_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) trd_q <= 1'b0;
    else       trd_q <= bus.trd;
  end

  assign trigger    = bus.trd & ~trd_q;
  assign unused_req = bus.req;
`else
  logic unused_trd;

  assign trigger    = bus.req;
  assign unused_trd = bus.trd;
`endif

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty_w = (count == '0);
  assign do_wr   = (state == DATA) && (bit_idx == 3'd7) && !full;
  assign do_pop  = bus.rd_en && !empty_w;

  // Bit 7 arrives on the same edge the byte is written, so splice it in directly.
  always_comb begin
    wr_byte    = shift;
    wr_byte[7] = bus.sd;
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      shift   <= '0;
      bit_idx <= '0;
      timer   <= '0;
      sbf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      frm_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      sbf_q <= 1'b0;
      if (do_wr)  wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_wr && !do_pop)      count <= count + (AW + 1)'(1);
      else if (!do_wr && do_pop) count <= count - (AW + 1)'(1);

      // The REQ flush is written after the FIFO bookkeeping so it takes priority.
      case (state)
        IDLE: begin
          if (trigger) begin
            state  <= REQ;
            sbf_q  <= 1'b1;
            busy_q <= 1'b1;
          end
        end
        REQ: begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
          done_q <= 1'b0;
          ovf_q  <= 1'b0;
          frm_q  <= 1'b0;
          to_q   <= 1'b0;
          timer  <= TW'(TIMEOUT);
          state  <= WAIT_START;
        end
        WAIT_START: begin
          if (!bus.cd && !bus.sd) begin
            bit_idx <= 3'd0;
            state   <= DATA;
          end else if (timer <= TW'(1)) begin
            to_q   <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        DATA: begin
          shift[bit_idx] <= bus.sd;
          bit_idx        <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            if (full) ovf_q <= 1'b1;
            state <= GAP;
          end
        end
        GAP: begin
          if (bus.cd) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (!bus.sd) begin
            bit_idx <= 3'd0;
            state   <= DATA;
          end else begin
            frm_q  <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.sbf          = sbf_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err_overflow = ovf_q;
  assign bus.err_frame    = frm_q;
  assign bus.err_timeout  = to_q;
  assign bus.empty        = empty_w;
  assign bus.byte_count   = count;
  assign bus.rd_data      = empty_w ? 8'h00 : mem[rd_ptr];
endmodule
